// File: rtl/rs_encode_stream.sv
// rs_encode_stream
//   Streaming systematic Reed-Solomon encoder over GF(2^SYM_W).
//   Message symbols pass straight through to the output with no register
//   stage while an LFSR accumulates m(x)*x^NPAR mod g(x). Once the last
//   message symbol of a frame is accepted, the NPAR parity symbols are
//   shifted out, highest degree first. The generator polynomial is built at
//   elaboration from consecutive roots alpha^GEN_START .. alpha^(GEN_START+NPAR-1).
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   clr_i           synchronous frame abort
//   in_valid_i/in_ready_o/in_data_i/in_last_i      message symbol stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o  codeword symbol stream
//   out_parity_o    current output symbol is a parity symbol
//   busy_o          a frame is in progress
//   len_err_o       one-cycle pulse when a frame is cut off at KMAX symbols
module rs_encode_stream #(
  parameter int unsigned SYM_W     = 8,
  parameter int unsigned NPAR      = 32,
  parameter int unsigned PRIM_POLY = 'h11D,
  parameter int unsigned GEN_START = 0,
  parameter int unsigned KMAX      = 168
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SYM_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SYM_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             out_parity_o,
  output logic             busy_o,
  output logic             len_err_o
);

  localparam int unsigned CNT_W  = $clog2(KMAX + 1);
  localparam int unsigned PCNT_W = (NPAR > 1) ? $clog2(NPAR) : 1;
  localparam logic [SYM_W-1:0] POLY_LO = PRIM_POLY[SYM_W-1:0];

  // GF(2^SYM_W) multiply; with one operand constant this collapses to XORs.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[SYM_W-1] ? ((aa << 1) ^ POLY_LO) : (aa << 1);
    end
    return p;
  endfunction

  // Low NPAR coefficients of the monic generator, index = degree.
  function automatic logic [NPAR-1:0][SYM_W-1:0] gen_poly();
    logic [NPAR:0][SYM_W-1:0] g;
    logic [SYM_W-1:0]         root;
    g    = '0;
    g[0] = SYM_W'(1);
    root = SYM_W'(1);
    for (int unsigned i = 0; i < GEN_START; i++) root = gf_mul(root, SYM_W'(2));
    for (int unsigned i = 0; i < NPAR; i++) begin
      for (int unsigned j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, SYM_W'(2));
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][SYM_W-1:0] GEN = gen_poly();

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } state_e;

  state_e                    state_q, state_d;
  logic [NPAR-1:0][SYM_W-1:0] r_q, r_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PCNT_W-1:0]         pcnt_q, pcnt_d;
  logic                      len_err_q, len_err_d;
  logic [SYM_W-1:0]          fb;
  logic                      kill;
  logic                      is_kmax;
  logic                      par_last;

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    len_err_d    = 1'b0;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_data_o   = in_data_i;
    out_last_o   = 1'b0;
    out_parity_o = 1'b0;

    // Reset and abort both block any handshake in the cycle they are seen.
    kill     = rst_i | clr_i;
    fb       = in_data_i ^ r_q[NPAR-1];
    is_kmax  = (cnt_q == CNT_W'(KMAX - 1));
    par_last = (pcnt_q == PCNT_W'(NPAR - 1));

    case (state_q)
      S_IDLE, S_DATA: begin
        in_ready_o  = out_ready_i & ~kill;
        out_valid_o = in_valid_i & ~kill;
        if (in_valid_i && in_ready_o) begin
          r_d[0] = gf_mul(GEN[0], fb);
          for (int unsigned i = 1; i < NPAR; i++) begin
            r_d[i] = r_q[i-1] ^ gf_mul(GEN[i], fb);
          end
          if (in_last_i || is_kmax) begin
            state_d   = S_PARITY;
            cnt_d     = '0;
            len_err_d = ~in_last_i;
          end else begin
            state_d = S_DATA;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        out_valid_o  = ~kill;
        out_data_o   = r_q[NPAR-1];
        out_parity_o = 1'b1;
        out_last_o   = par_last & ~kill;
        if (out_ready_i && !kill) begin
          r_d = {r_q[NPAR-2:0], SYM_W'(0)};
          if (par_last) begin
            pcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d = S_IDLE;
      r_d     = '0;
      cnt_d   = '0;
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign len_err_o = len_err_q;

endmodule

// File: tb/tb_rs_encode_stream.sv
// tb_rs_encode_stream
//   Two encoder instances: A uses the default RS(200,168) configuration,
//   B uses NPAR=2, KMAX=4. Expected codeword symbols are queued when a
//   frame is issued and popped as the DUT hands symbols downstream.
module tb_rs_encode_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_clr, a_iv, a_ir, a_il, a_ov, a_or, a_ol, a_op, a_busy, a_le;
  logic [7:0] a_id, a_od;
  logic       b_rst, b_clr, b_iv, b_ir, b_il, b_ov, b_or, b_ol, b_op, b_busy, b_le;
  logic [7:0] b_id, b_od;

  rs_encode_stream #(
    .SYM_W(8), .NPAR(32), .PRIM_POLY('h11D), .GEN_START(0), .KMAX(168)
  ) u_a (
    .clk_i(clk), .rst_i(a_rst), .clr_i(a_clr),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id), .in_last_i(a_il),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .out_last_o(a_ol),
    .out_parity_o(a_op), .busy_o(a_busy), .len_err_o(a_le)
  );

  rs_encode_stream #(
    .SYM_W(8), .NPAR(2), .PRIM_POLY('h11D), .GEN_START(0), .KMAX(4)
  ) u_b (
    .clk_i(clk), .rst_i(b_rst), .clr_i(b_clr),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id), .in_last_i(b_il),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .out_last_o(b_ol),
    .out_parity_o(b_op), .busy_o(b_busy), .len_err_o(b_le)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       par;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   gexp[0:511];
  int   glog[0:255];
  int   msg[0:255];
  int   par[0:63];
  int   a_le_cnt = 0;
  logic a_rnd = 1'b0;

  logic [7:0] pd[2];
  logic       pl[2];
  logic       pp[2];
  logic       pstall[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int d, input bit l, input bit p);
    exp_t e;
    e.d    = 8'(d);
    e.last = l;
    e.par  = p;
    return e;
  endfunction

  function automatic void init_gf();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i]       = x;
      gexp[i + 255] = x;
      glog[x]       = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  // Parity by long division of m(x)*x^npar by g(x); fills par[0..npar-1].
  function automatic void encode(input int k, input int npar);
    int g[0:64];
    int b[0:319];
    int c;
    for (int j = 0; j <= 64; j++) g[j] = 0;
    g[0] = 1;
    for (int i = 0; i < npar; i++) begin
      for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gmul(g[j], gexp[i]);
      g[0] = gmul(g[0], gexp[i]);
    end
    for (int i = 0; i < 320; i++) b[i] = (i < k) ? msg[i] : 0;
    for (int i = 0; i < k; i++) begin
      c = b[i];
      if (c != 0) for (int j = 1; j <= npar; j++) b[i+j] = b[i+j] ^ gmul(c, g[npar-j]);
    end
    for (int j = 0; j < npar; j++) par[j] = b[k+j];
  endfunction

  task automatic push_frame(input int k, input int n, input int npar);
    encode(n, npar);
    for (int i = 0; i < n; i++) begin
      if (k == 0) qa.push_back(mk(msg[i], 1'b0, 1'b0));
      else        qb.push_back(mk(msg[i], 1'b0, 1'b0));
    end
    for (int j = 0; j < npar; j++) begin
      if (k == 0) qa.push_back(mk(par[j], j == npar - 1, 1'b1));
      else        qb.push_back(mk(par[j], j == npar - 1, 1'b1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input int k, input int d, input bit l);
    logic acc;
    int   c;
    acc = 1'b0;
    c   = 0;
    if (k == 0) begin a_iv = 1'b1; a_id = 8'(d); a_il = l; end
    else        begin b_iv = 1'b1; b_id = 8'(d); b_il = l; end
    while (!acc && c < 2000) begin
      @(negedge clk);
      acc = (k == 0) ? a_ir : b_ir;
      @(posedge clk);
      #1;
      c++;
    end
    chk("send_accept", acc, 1);
    if (k == 0) a_iv = 1'b0;
    else        b_iv = 1'b0;
  endtask

  task automatic send_frame(input int k, input int n, input bit with_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) tick();
      send_sym(k, msg[i], with_last && (i == n - 1));
    end
  endtask

  task automatic drain(input int k);
    int c;
    c = 0;
    while (((k == 0) ? qa.size() : qb.size()) != 0 && c < 4000) begin
      tick();
      c++;
    end
    chk("drain_empty", (k == 0) ? qa.size() : qb.size(), 0);
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic [7:0] d,
                     input logic l, input logic p);
    exp_t e;
    int   sz;
    if (pstall[k]) begin
      chk("stall_valid", v, 1);
      chk("stall_data", d, pd[k]);
      chk("stall_last", l, pl[k]);
      chk("stall_par", p, pp[k]);
    end
    if (v && r) begin
      sz = (k == 0) ? qa.size() : qb.size();
      chk("sb_nonempty", sz != 0, 1);
      if (sz != 0) begin
        e = (k == 0) ? qa.pop_front() : qb.pop_front();
        chk("out_data", d, e.d);
        chk("out_last", l, e.last);
        chk("out_parity", p, e.par);
      end
    end
    pstall[k] = v && !r;
    pd[k]     = d;
    pl[k]     = l;
    pp[k]     = p;
  endtask

  always @(negedge clk) begin
    if (a_rst) pstall[0] = 1'b0;
    else       mon(0, a_ov, a_or, a_od, a_ol, a_op);
    if (b_rst) pstall[1] = 1'b0;
    else       mon(1, b_ov, b_or, b_od, b_ol, b_op);
    if (a_le) a_le_cnt++;
  end

  always @(posedge clk) begin
    #1;
    a_or = a_rnd ? ($urandom_range(3) != 0) : 1'b1;
  end

  initial begin
    int le0;
    init_gf();
    a_rst = 1'b1; a_clr = 1'b0; a_iv = 1'b1; a_id = 8'hAA; a_il = 1'b0;
    b_rst = 1'b1; b_clr = 1'b0; b_iv = 1'b1; b_id = 8'h55; b_il = 1'b0; b_or = 1'b1;
    pstall[0] = 1'b0;
    pstall[1] = 1'b0;

    // Reset gating while inputs request a transfer.
    tick();
    tick();
    @(negedge clk);
    chk("rst_a_in_ready", a_ir, 0);
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_b_in_ready", b_ir, 0);
    chk("rst_b_out_valid", b_ov, 0);
    @(posedge clk);
    #1;
    a_rst = 1'b0; a_iv = 1'b0;
    b_rst = 1'b0; b_iv = 1'b0;
    tick();
    chk("post_rst_a_busy", a_busy, 0);
    chk("post_rst_a_last", a_ol, 0);
    chk("post_rst_a_par", a_op, 0);
    chk("post_rst_a_lenerr", a_le, 0);
    chk("post_rst_b_busy", b_busy, 0);
    chk("post_rst_b_lenerr", b_le, 0);

    // Single-symbol frame: 01 -> 01 03 02.
    qb.push_back(mk('h01, 1'b0, 1'b0));
    qb.push_back(mk('h03, 1'b0, 1'b1));
    qb.push_back(mk('h02, 1'b1, 1'b1));
    send_sym(1, 'h01, 1'b1);
    drain(1);
    chk("one_sym_busy_after", b_busy, 0);

    // KMAX cut-off: four symbols without last.
    msg[0] = 'h10; msg[1] = 'h20; msg[2] = 'h30; msg[3] = 'h40;
    push_frame(1, 4, 2);
    send_frame(1, 4, 1'b0, 1'b0);
    chk("kmax_lenerr_pulse", b_le, 1);
    chk("kmax_busy", b_busy, 1);
    chk("kmax_parity_state", b_op, 1);
    tick();
    chk("kmax_lenerr_drop", b_le, 0);
    msg[0] = 'h77;
    push_frame(1, 1, 2);
    send_sym(1, 'h77, 1'b1);
    drain(1);
    chk("kmax_next_busy", b_busy, 0);

    // Abort after three symbols; the clr cycle carries a dominated handshake.
    qb.push_back(mk('h11, 1'b0, 1'b0));
    qb.push_back(mk('h22, 1'b0, 1'b0));
    qb.push_back(mk('h33, 1'b0, 1'b0));
    send_sym(1, 'h11, 1'b0);
    send_sym(1, 'h22, 1'b0);
    send_sym(1, 'h33, 1'b0);
    b_clr = 1'b1; b_iv = 1'b1; b_id = 8'h55; b_il = 1'b1;
    @(negedge clk);
    chk("clr_out_valid", b_ov, 0);
    chk("clr_in_ready", b_ir, 0);
    chk("clr_out_last", b_ol, 0);
    @(posedge clk);
    #1;
    b_clr = 1'b0; b_iv = 1'b0; b_il = 1'b0;
    chk("clr_busy", b_busy, 0);
    qb.push_back(mk('h01, 1'b0, 1'b0));
    qb.push_back(mk('h03, 1'b0, 1'b1));
    qb.push_back(mk('h02, 1'b1, 1'b1));
    send_sym(1, 'h01, 1'b1);
    drain(1);

    // Reset while the second parity symbol is pending.
    qb.push_back(mk('h01, 1'b0, 1'b0));
    qb.push_back(mk('h03, 1'b0, 1'b1));
    send_sym(1, 'h01, 1'b1);
    tick();
    chk("pre_rst_parity_cnt1_last", b_ol, 1);
    b_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", b_ov, 0);
    chk("rst_mid_in_ready", b_ir, 0);
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    chk("rst_mid_busy", b_busy, 0);
    chk("rst_mid_valid_after", b_ov, 0);
    chk("rst_mid_sb_empty", qb.size(), 0);
    qb.push_back(mk('h01, 1'b0, 1'b0));
    qb.push_back(mk('h03, 1'b0, 1'b1));
    qb.push_back(mk('h02, 1'b1, 1'b1));
    send_sym(1, 'h01, 1'b1);
    drain(1);

    // All-zero 168-symbol frame on the default configuration.
    le0 = a_le_cnt;
    for (int i = 0; i < 168; i++) msg[i] = 0;
    push_frame(0, 168, 32);
    send_frame(0, 168, 1'b1, 1'b0);
    drain(0);
    chk("zero_frame_no_lenerr", a_le_cnt - le0, 0);
    chk("zero_frame_busy", a_busy, 0);

    // Random back-to-back frames with stalls on both sides.
    a_rnd = 1'b1;
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 168; i++) msg[i] = $urandom_range(255);
      push_frame(0, 168, 32);
      send_frame(0, 168, 1'b1, 1'b1);
    end
    drain(0);
    a_rnd = 1'b0;
    chk("rand_no_lenerr", a_le_cnt - le0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_encode_stream.md
RS_ENCODE_STREAM -- requirements
Module: rs_encode_stream

Interface
REQ-001 Parameter SYM_W, default 8: symbol width in bits, GF(2^SYM_W); legal range 3..12.
REQ-002 Parameter NPAR, default 32: parity symbols per codeword; even, 2..64.
REQ-003 Parameter PRIM_POLY, default 'h11D: field primitive polynomial, SYM_W+1 bits.
REQ-004 Parameter GEN_START, default 0: exponent of first consecutive generator root. g(x) = product over i=0..NPAR-1 of (x + alpha^(GEN_START+i)); coefficients computed at elaboration.
REQ-005 Parameter KMAX, default 168: maximum message symbols per frame; KMAX+NPAR <= 2^SYM_W-1.
REQ-006 Reset: one clock; reset is synchronous and active-high.
REQ-007 Ports:
 clk_i  in  1  clock.
 rst_i  in  1  synchronous active-high reset.
 clr_i  in  1  synchronous frame abort.
 in_valid_i  in  1  message symbol valid.
 in_ready_o  out  1  message symbol accepted when high with in_valid_i.
 in_data_i  in  SYM_W  message symbol, first symbol = highest-degree coefficient.
 in_last_i  in  1  marks final message symbol of frame.
 out_valid_o  out  1  codeword symbol valid.
 out_ready_i  in  1  downstream accepts codeword symbol.
 out_data_o  out  SYM_W  codeword symbol.
 out_last_o  out  1  final codeword symbol.
 out_parity_o  out  1  current output symbol is parity.
 busy_o  out  1  frame in progress (state != IDLE).
 len_err_o  out  1  one-cycle pulse on forced frame termination.

Function
REQ-008 Systematic encoding: codeword = message symbols in order, then NPAR parity symbols = coefficients of m(x)*x^NPAR mod g(x), highest degree first.
REQ-009 States IDLE, DATA, PARITY. IDLE->DATA on first accepted symbol with in_last_i=0 and KMAX>1; IDLE/DATA->PARITY on accepted symbol that is last (REQ-013); PARITY->IDLE on accepted final parity symbol.
REQ-010 IDLE/DATA: out_valid_o=in_valid_i, out_data_o=in_data_i, in_ready_o=out_ready_i, out_parity_o=0, out_last_o=0; zero-cycle pass-through, no data register.
REQ-011 LFSR r[0..NPAR-1], SYM_W each, updated on each accepted message symbol: fb=in_data_i^r[NPAR-1]; r[0]<=g0*fb; r[i]<=r[i-1]^gi*fb, all constant GF multiplies.
REQ-012 PARITY: in_ready_o=0; out_valid_o=1; out_data_o=r[NPAR-1]; out_parity_o=1; each accepted symbol shifts r[i]<=r[i-1], r[0]<=0; parity counter counts 0..NPAR-1; out_last_o=1 on count NPAR-1.
REQ-013 A symbol is last when in_last_i=1 or it is the KMAX-th symbol of the frame; if KMAX-th and in_last_i=0, len_err_o pulses high the cycle after acceptance.
REQ-014 First parity symbol is valid the cycle after the last message symbol is accepted.
REQ-015 out_ready_i low: out_data_o, out_last_o, out_parity_o stable while out_valid_o high in PARITY; LFSR and counters hold.
REQ-016 Message symbol counter, clog2(KMAX+1) bits, clears on frame end; never wraps.
REQ-017 clr_i high: next cycle state=IDLE, LFSR and counters zero; no out_last_o for abandoned frame; clr_i dominates any same-cycle handshake (symbol not encoded); out_valid_o/in_ready_o forced 0 during the clr_i cycle.
REQ-018 Back-to-back frames: new frame symbol accepted the cycle after the final parity symbol is accepted.

Reset
REQ-019 rst_i high: next cycle state=IDLE, LFSR, counters, len_err_o zero; in_ready_o=0 and out_valid_o=0 while rst_i high; rst_i mid-frame discards frame; rst_i dominates clr_i.
REQ-020 After reset release: out_last_o=0, out_parity_o=0, busy_o=0, len_err_o=0.

Verification
REQ-021 SYM_W=8, NPAR=2, GEN_START=0, poly 'h11D (g=x^2+3x+2): message 01 with last, out_ready_i=1 -> output 01, 03, 02; out_last_o on 02; busy_o low next cycle.
REQ-022 Defaults: 168 zero symbols, last on 168th -> 200 zero symbols, out_parity_o high on symbols 169-200, out_last_o only on 200th, len_err_o never pulses.
REQ-023 Defaults, 200 random 168-symbol frames, random out_ready_i/in_valid_i stalls -> codeword bit-exact vs software RS(200,168); outputs stable across every stall.
REQ-024 KMAX=4, NPAR=2: 4 symbols, in_last_i=0 -> 4th treated as last, len_err_o one-cycle pulse, 2 parity symbols follow, 5th input waits for next frame.
REQ-025 Assert clr_i after 3 message symbols, then send 01 with last -> abandoned frame has no out_last_o; next codeword 01, 03, 02 (NPAR=2 config).
REQ-026 Assert rst_i during PARITY count 1 -> next cycle out_valid_o=0, busy_o=0; following frame encodes correctly.
